// File: rtl/green_led_fader_pkg.sv
// rtl/green_led_fader_pkg.sv - shared constants, CSR address map and helpers for the green LED fader
package green_led_fader_pkg;

    localparam int PWM_MAX = 255;

    typedef enum logic [1:0] {
        CSR_STEP   = 2'd0,
        CSR_CTRL   = 2'd1,
        CSR_STATUS = 2'd2,
        CSR_RSVD   = 2'd3
    } csr_addr_e;

    localparam logic [1:0] ADDR_STEP   = CSR_STEP;
    localparam logic [1:0] ADDR_CTRL   = CSR_CTRL;
    localparam logic [1:0] ADDR_STATUS = CSR_STATUS;

    localparam int CTRL_BYPASS_BIT = 0;

    // A programmed period of zero is treated as one clock per step.
    function automatic logic [15:0] eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// rtl/led_fader_channel.sv - one LED channel: saturating brightness level and registered PWM compare
module led_fader_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                target,
    input  logic                bypass,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                busy,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic [PWM_BITS-1:0] lvl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl     <= '0;
            led_out <= 1'b0;
        end else begin
            if (tick) begin
                if (target && (lvl != LVL_MAX)) begin
                    lvl <= lvl + 1'b1;
                end else if (!target && (lvl != '0)) begin
                    lvl <= lvl - 1'b1;
                end
            end
            // pwm_cnt never reaches LVL_MAX, so a full level is solid on
            led_out <= bypass ? target : (pwm_cnt < lvl);
        end
    end

    assign busy = target ? (lvl != LVL_MAX) : (lvl != '0);

endmodule

// File: rtl/green_led_fader.sv
// rtl/green_led_fader.sv - PWM fader between the green LED PIO port and the LED pins; CSR block under GREEN_LED_FADER_CSR_EN
module green_led_fader
    import green_led_fader_pkg::*;
#(
    parameter int N_LEDS       = 9,
    parameter int PWM_BITS     = 8,
    parameter int STEP_DEFAULT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_in,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic [N_LEDS-1:0] led_out
);

    localparam logic [15:0]         STEP_RST = 16'(STEP_DEFAULT);
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [N_LEDS-1:0]   target;
    logic [N_LEDS-1:0]   busy;
    logic [15:0]         step_period;
    logic [15:0]         presc;
    logic [15:0]         period_last;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                bypass;

    assign period_last = eff_period(step_period) - 16'd1;
    // >= rather than == so a shortened period takes effect immediately
    assign tick        = (presc >= period_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
            target  <= '0;
        end else begin
            presc   <= tick ? 16'd0 : presc + 16'd1;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            target  <= led_in;
        end
    end

`ifdef GREEN_LED_FADER_CSR_EN
    logic [15:0] step_q;
    logic        ctrl_bypass;
    logic        csr_wr;

    assign csr_wr = chipselect && !write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q      <= STEP_RST;
            ctrl_bypass <= 1'b0;
        end else if (csr_wr) begin
            case (csr_addr_e'(address))
                CSR_STEP: step_q      <= writedata;
                CSR_CTRL: ctrl_bypass <= writedata[CTRL_BYPASS_BIT];
                default:  ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (csr_addr_e'(address))
            CSR_STEP:   readdata = step_q;
            CSR_CTRL:   readdata[CTRL_BYPASS_BIT] = ctrl_bypass;
            CSR_STATUS: readdata[N_LEDS-1:0] = busy;
            default:    readdata = '0;
        endcase
    end

    assign step_period = step_q;
    assign bypass      = ctrl_bypass;
`else
    logic unused_csr;

    assign unused_csr  = ^{address, chipselect, write_n, writedata, busy};
    assign step_period = STEP_RST;
    assign bypass      = 1'b0;
    assign readdata    = '0;
`endif

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .target (target[i]),
            .bypass (bypass),
            .pwm_cnt(pwm_cnt),
            .busy   (busy[i]),
            .led_out(led_out[i])
        );
    end

endmodule

// File: tb/tb_green_led_fader.sv
// tb/tb_green_led_fader.sv - scoreboard bench for green_led_fader (both GREEN_LED_FADER_CSR_EN builds)
module tb_green_led_fader;
    import green_led_fader_pkg::*;

    localparam int N = 9;
`ifdef GREEN_LED_FADER_CSR_EN
    localparam int RST_STEP_RD = 1024;
    localparam int STATUS_ALL  = 'h1FF;
`else
    localparam int RST_STEP_RD = 0;
    localparam int STATUS_ALL  = 0;
`endif

    typedef enum int {K_RD, K_LED, K_DUTY} kind_e;
    typedef struct {
        string name;
        kind_e kind;
        int    ch;
        int    exp;
    } chk_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] led_in = '0;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [15:0]  writedata = '0;
    logic [15:0]  readdata;
    logic [N-1:0] led_out;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    chk_t exp_q[$];
    event chk_ev;
    bit   mon_busy = 1'b0;

    green_led_fader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_in    (led_in),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin : monitor
        chk_t c;
        int   got;
        forever begin
            @(chk_ev);
            #1;
            mon_busy = 1'b1;
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                got = 0;
                case (c.kind)
                    K_RD:  got = int'(readdata);
                    K_LED: got = int'(led_out);
                    default: begin
                        for (int k = 0; k < 255; k++) begin
                            if (k > 0) begin
                                @(negedge clk);
                                #1;
                            end
                            got += int'(led_out[c.ch]);
                        end
                    end
                endcase
                n_tests++;
                if (got != c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, got, c.exp);
                end
            end
            mon_busy = 1'b0;
        end
    end

    task automatic check(input string name, input kind_e kind, input int ch, input int exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.ch   = ch;
        c.exp  = exp;
        exp_q.push_back(c);
        ->chk_ev;
        #2;
        for (int g = 0; g < 400 && (exp_q.size() != 0 || mon_busy); g++) @(negedge clk);
        if (exp_q.size() != 0 || mon_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: monitor did not finish, expected 0x%0h", name, exp);
        end
    endtask

    task automatic check_rd(input string name, input logic [1:0] a, input int exp);
        address = a;
        check(name, K_RD, 0, exp);
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [15:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wait_cyc(input int k);
        for (int g = 0; g < 100000 && cyc < k; g++) @(negedge clk);
    endtask

    // Exactly n ticks: the first write makes every cycle a tick, the closing
    // write's own edge still ticks with the fast period.
    task automatic run_ticks(input int n, input logic [15:0] fast, input logic [15:0] fin);
        csr_write(ADDR_STEP, fast, 1'b1);
        repeat (n - 1) @(negedge clk);
        csr_write(ADDR_STEP, fin, 1'b1);
    endtask

    task automatic set_led_in(input logic [N-1:0] v);
        led_in = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_fade();
        csr_write(ADDR_STEP, 16'd4, 1'b1);
        led_in = 9'h1FF;
        repeat (200) @(negedge clk);
        for (int g = 0; g < 600 && led_out == '0; g++) @(negedge clk);
        n_tests++;
        if (led_out == '0) begin
            n_fail++;
            $display("FAIL rst_pre_led: got 0x0, expected nonzero led_out before reset");
        end
        #2 reset_n = 1'b0;
        check("rst_async_led", K_LED, 0, 0);
        repeat (2) @(negedge clk);
        check_rd("rst_step_rd", ADDR_STEP, RST_STEP_RD);
        check_rd("rst_status_rd", ADDR_STATUS, 0);
        reset_n = 1'b1;
        wait_cyc(5);
        check_rd("post_rst_status", ADDR_STATUS, STATUS_ALL);
        wait_cyc(100);
        check("post_rst_duty0", K_DUTY, 0, 0);
        wait_cyc(1124);
        check("post_rst_duty1", K_DUTY, 0, 1);
        check("post_rst_duty8", K_DUTY, 8, 1);
    endtask

`ifdef GREEN_LED_FADER_CSR_EN
    task automatic csr_flow();
        reset_n = 1'b1;
        csr_write(ADDR_STEP, 16'd4, 1'b1);
        led_in = 9'h001;
        check_rd("fade_step_rd", ADDR_STEP, 4);
        wait_cyc(10);
        check_rd("fade_status_busy", ADDR_STATUS, 'h001);
        wait_cyc(1019);
        check_rd("fade_status_254", ADDR_STATUS, 'h001);
        wait_cyc(1020);
        check_rd("fade_status_done", ADDR_STATUS, 'h000);
        wait_cyc(1021);
        check("fade_led_full", K_LED, 0, 'h001);
        check("fade_duty0_full", K_DUTY, 0, PWM_MAX);
        check("fade_duty1_off", K_DUTY, 1, 0);

        csr_write(ADDR_STEP, 16'hFFFF, 1'b1);
        set_led_in(9'h000);
        run_ticks(255, 16'd1, 16'hFFFF);
        check_rd("duty_status_idle", ADDR_STATUS, 0);
        set_led_in(9'h001);
        run_ticks(128, 16'd1, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("duty_128_a", K_DUTY, 0, 128);
        repeat (37) @(negedge clk);
        check("duty_128_b", K_DUTY, 0, 128);

        set_led_in(9'h000);
        run_ticks(200, 16'd1, 16'hFFFF);
        set_led_in(9'h003);
        run_ticks(100, 16'd0, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("rev_up_duty0", K_DUTY, 0, 100);
        check("rev_up_duty1", K_DUTY, 1, 100);
        set_led_in(9'h000);
        run_ticks(30, 16'd1, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("rev_down_duty0", K_DUTY, 0, 70);
        check_rd("rev_status_busy", ADDR_STATUS, 'h003);
        run_ticks(80, 16'd1, 16'hFFFF);
        repeat (2) @(negedge clk);
        check_rd("rev_status_idle", ADDR_STATUS, 0);
        check("rev_led_end", K_LED, 0, 0);
        check("rev_sat_duty0", K_DUTY, 0, 0);

        csr_write(ADDR_CTRL, 16'hFFFF, 1'b1);
        check_rd("byp_ctrl_rd", ADDR_CTRL, 1);
        led_in = 9'h1AA;
        @(negedge clk);
        check("byp_lat1", K_LED, 0, 'h000);
        @(negedge clk);
        check("byp_lat2", K_LED, 0, 'h1AA);
        run_ticks(255, 16'd1, 16'hFFFF);
        check_rd("byp_status_done", ADDR_STATUS, 0);
        csr_write(ADDR_CTRL, 16'd0, 1'b1);
        @(negedge clk);
        check("byp_off_led", K_LED, 0, 'h1AA);
        set_led_in(9'h000);
        check("byp_bg_led", K_LED, 0, 'h1AA);
        check_rd("byp_bg_status", ADDR_STATUS, 'h1AA);
        csr_write(ADDR_CTRL, 16'd1, 1'b1);
        check("byp_on_lat0", K_LED, 0, 'h1AA);
        @(negedge clk);
        check("byp_on_lat1", K_LED, 0, 'h000);
        csr_write(ADDR_CTRL, 16'd0, 1'b1);
        @(negedge clk);
        check("byp_resume_led", K_LED, 0, 'h1AA);
        csr_write(ADDR_CTRL, 16'd1, 1'b0);
        check_rd("csr_nocs_ctrl", ADDR_CTRL, 0);
        csr_write(2'd3, 16'h1234, 1'b1);
        check_rd("csr_rsvd_rd", 2'd3, 0);
        check_rd("csr_step_keep", ADDR_STEP, 'hFFFF);

        run_ticks(255, 16'd1, 16'hFFFF);
        set_led_in(9'h001);
        run_ticks(1, 16'd1, 16'hFFFF);
        set_led_in(9'h003);
        run_ticks(1, 16'd1, 16'hFFFF);
        set_led_in(9'h007);
        run_ticks(252, 16'd1, 16'd1000);
        check_rd("presc_prep", ADDR_STATUS, 'h007);
        repeat (100) @(negedge clk);
        csr_write(ADDR_STEP, 16'd2, 1'b1);
        check_rd("presc_w101", ADDR_STATUS, 'h007);
        @(negedge clk);
        check_rd("presc_w102", ADDR_STATUS, 'h006);
        @(negedge clk);
        check_rd("presc_w103", ADDR_STATUS, 'h006);
        @(negedge clk);
        check_rd("presc_w104", ADDR_STATUS, 'h004);
        @(negedge clk);
        check_rd("presc_w105", ADDR_STATUS, 'h004);
        @(negedge clk);
        check_rd("presc_w106", ADDR_STATUS, 'h000);
        check_rd("presc_step_rd", ADDR_STEP, 2);
    endtask
`else
    task automatic basic_flow();
        led_in  = 9'h001;
        reset_n = 1'b1;
        csr_write(ADDR_STEP, 16'd4, 1'b1);
        csr_write(ADDR_CTRL, 16'd1, 1'b1);
        check_rd("nocsr_step_rd", ADDR_STEP, 0);
        check_rd("nocsr_ctrl_rd", ADDR_CTRL, 0);
        check_rd("nocsr_status_rd", ADDR_STATUS, 0);
        wait_cyc(500);
        check("base_led_pre_tick", K_LED, 0, 0);
        wait_cyc(1124);
        check("base_duty_lvl1", K_DUTY, 0, 1);
        wait_cyc(20580);
        check("base_duty_lvl20", K_DUTY, 0, 20);
        check("base_duty_ch1_off", K_DUTY, 1, 0);
        wait_cyc(21100);
        led_in = 9'h002;
        wait_cyc(21604);
        check("base_rev_ch0_19", K_DUTY, 0, 19);
        check("base_rev_ch1_1", K_DUTY, 1, 1);
        wait_cyc(41000);
        check("base_rev_ch0_0", K_DUTY, 0, 0);
        check("base_rev_ch1_20", K_DUTY, 1, 20);
        wait_cyc(42100);
        check("base_sat_ch0", K_DUTY, 0, 0);
    endtask
`endif

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_led", K_LED, 0, 0);
        check_rd("rst_step", ADDR_STEP, RST_STEP_RD);
        check_rd("rst_ctrl", ADDR_CTRL, 0);
        check_rd("rst_status", ADDR_STATUS, 0);
        check_rd("rst_rsvd", 2'd3, 0);
`ifdef GREEN_LED_FADER_CSR_EN
        csr_flow();
`else
        basic_flow();
`endif
        reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: time limit reached, expected stimulus to complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
